// File: rtl/par2ser_mem_writer.sv
// par2ser_mem_writer: accepts a beat of LANES parallel words and writes them
// one per cycle (lane 0 first) into a single-port memory write interface.
// The address wraps at DEPTH. A synchronous address clear is supported.
// Beats offered while the block is not ready are dropped and reported.
// Optional feature macro: OVERFLOW_CNT_EN adds a saturating 16-bit drop_count
// output. It is cleared together with the address.
module par2ser_mem_writer #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned LANES  = 2,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [LANES*DATA_W-1:0] data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic                    addr_clr,
  output logic [DATA_W-1:0]       data,
  output logic [ADDR_W-1:0]       addr,
  output logic                    wea,
  output logic                    busy,
  output logic                    overflow
`ifdef OVERFLOW_CNT_EN
  ,
  output logic [15:0]             drop_count
`endif
);

  localparam int unsigned BEAT_W = LANES * DATA_W;
  localparam int unsigned CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(LANES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   lane_cnt;
  logic [BEAT_W-1:0]  hold;
  logic [ADDR_W-1:0]  wr_ptr;
  logic               clr_pend;
  logic               last_lane_c;
  logic               accept_c;
  logic               drop_c;
  logic               clr_now_c;

  // Wrap-around increment of the write pointer
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  // Handshake decode: ready on the last lane allows back-to-back beats
  assign last_lane_c = (state == SHIFT) && (lane_cnt == LAST_LANE);
  assign ready_out   = (state == IDLE) || last_lane_c;
  assign busy        = (state == SHIFT);
  assign accept_c    = valid_in && ready_out;
  assign drop_c      = valid_in && !ready_out;
  // Point at which an address clear actually takes effect
  assign clr_now_c   = ((state == IDLE) && addr_clr) ||
                       (last_lane_c && (clr_pend || addr_clr));

  // Serialiser FSM with registered memory-side outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      lane_cnt <= '0;
      hold     <= '0;
      wr_ptr   <= '0;
      clr_pend <= 1'b0;
      data     <= '0;
      addr     <= '0;
      wea      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop_c;
      case (state)
        IDLE: begin
          wea <= 1'b0;
          if (addr_clr) begin
            wr_ptr <= '0;
            addr   <= '0;
          end
          if (accept_c) begin
            hold     <= data_in;
            lane_cnt <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          wea      <= 1'b1;
          data     <= hold[int'(lane_cnt) * DATA_W +: DATA_W];
          addr     <= wr_ptr;
          lane_cnt <= lane_cnt + CNT_W'(1);
          if (last_lane_c) begin
            // A clear requested during the beat lands only after its last word
            wr_ptr   <= (clr_pend || addr_clr) ? '0 : next_addr(wr_ptr);
            clr_pend <= 1'b0;
            if (accept_c) begin
              hold     <= data_in;
              lane_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            wr_ptr <= next_addr(wr_ptr);
            if (addr_clr) begin
              clr_pend <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OVERFLOW_CNT_EN
  // Saturating count of dropped beats, cleared alongside the address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (clr_now_c) begin
      drop_count <= '0;
    end else if (drop_c && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_par2ser_mem_writer.sv
// Self-checking bench for par2ser_mem_writer (LANES=4, DEPTH=16 inside a 5-bit address space).
module tb_par2ser_mem_writer;

  localparam int unsigned DATA_W = 18;
  localparam int unsigned LANES  = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned BEAT_W = LANES * DATA_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [BEAT_W-1:0] data_in = '0;
  logic              valid_in = 1'b0;
  logic              ready_out;
  logic              addr_clr = 1'b0;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              wea;
  logic              busy;
  logic              overflow;
`ifdef OVERFLOW_CNT_EN
  logic [15:0]       drop_count;
`endif

  par2ser_mem_writer #(
    .DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .addr_clr(addr_clr), .data(data), .addr(addr),
    .wea(wea), .busy(busy), .overflow(overflow)
`ifdef OVERFLOW_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } exp_t;

  exp_t wq[$];
  int   ovf_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: beats in flight, write pointer, pending clear, drop count
  int   m_left = 0;
  int   m_ptr  = 0;
  bit   m_pend = 0;
  int   m_cnt  = 0;

  bit                mon_on = 0;
  logic [DATA_W-1:0] mon_last = '0;
  exp_t              mon_e;
  logic              exp_o;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [BEAT_W-1:0] rand_beat();
    logic [BEAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return r;
  endfunction

  // Predict the effect of the coming rising edge given the inputs being applied
  task automatic model(input logic v, input logic [BEAT_W-1:0] d, input logic clr);
    bit rdy;
    rdy = (m_left <= 1);
    if (clr) begin
      if (m_left == 0) begin m_ptr = 0; m_cnt = 0; end
      else m_pend = 1;
    end
    if (m_left == 1 && m_pend) begin m_ptr = 0; m_pend = 0; m_cnt = 0; end
    if (v && rdy) begin
      for (int i = 0; i < LANES; i++) begin
        wq.push_back('{cyc + 2 + i, ADDR_W'(m_ptr), d[i*DATA_W +: DATA_W]});
        m_ptr = (m_ptr == DEPTH - 1) ? 0 : m_ptr + 1;
      end
      m_left = LANES;
    end else begin
      if (v) begin
        ovf_q.push_back(cyc + 1);
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      if (m_left > 0) m_left--;
    end
  endtask

  // One cycle: check status against model, apply inputs, advance to next negedge
  task automatic step(input logic v, input logic [BEAT_W-1:0] d, input logic clr);
    chk("ready_out", 64'(ready_out), 64'(m_left <= 1));
    chk("busy", 64'(busy), 64'(m_left != 0));
`ifdef OVERFLOW_CNT_EN
    chk("drop_count", 64'(drop_count), 64'(m_cnt));
`endif
    valid_in = v;
    data_in  = d;
    addr_clr = clr;
    model(v, d, clr);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0);
  endtask

  // Monitor: pop the scoreboard on every write and check the overflow pulse
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_last = '0;
    end else if (mon_on) begin
      if (wea) begin
        if (wq.size() == 0) begin
          chk("unexpected_wea", 64'(wea), 64'(0));
        end else begin
          mon_e = wq.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("wr_addr", 64'(addr), 64'(mon_e.a));
          chk("wr_data", 64'(data), 64'(mon_e.d));
          mon_last = mon_e.d;
        end
      end else begin
        chk("data_hold", 64'(data), 64'(mon_last));
        if (wq.size() != 0 && wq[0].cyc <= cyc) begin
          chk("missing_wea", 64'(wea), 64'(1));
          wq.delete(0);
        end
      end
      exp_o = (ovf_q.size() != 0 && ovf_q[0] == cyc);
      if (exp_o) ovf_q.delete(0);
      chk("overflow", 64'(overflow), 64'(exp_o));
    end
  end

  initial begin
    logic [BEAT_W-1:0] b;
    int nb;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_data", 64'(data), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_wea", 64'(wea), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_ready", 64'(ready_out), 64'(1));
    reset_n = 1'b1;
    mon_on  = 1;

    // Single directed beat starting at address 0
    b = '0;
    for (int i = 0; i < LANES; i++) b[i*DATA_W +: DATA_W] = DATA_W'((i + 1) * 32'h1_0001);
    step(1'b1, b, 1'b0);
    idle(6);

    // Three back-to-back beats offered exactly when ready
    nb = 0;
    while (nb < 3) begin
      if (m_left <= 1) begin step(1'b1, rand_beat(), 1'b0); nb++; end
      else step(1'b0, '0, 1'b0);
    end
    idle(6);

    // Beat offered at lane counter 1 is dropped
    step(1'b1, rand_beat(), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, rand_beat(), 1'b0);
    idle(6);

    // Address clear during lane 1 lands after the beat, next beat starts at 0
    step(1'b1, rand_beat(), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    idle(4);
    step(1'b1, rand_beat(), 1'b0);
    idle(6);

    // Clear and accept on the same idle edge
    step(1'b1, rand_beat(), 1'b1);
    idle(6);

    // Reset during lane 2 of a beat
    step(1'b1, rand_beat(), 1'b0);
    idle(3);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_wea", 64'(wea), 64'(0));
    chk("midrst_addr", 64'(addr), 64'(0));
    wq.delete();
    ovf_q.delete();
    m_left = 0; m_ptr = 0; m_pend = 0; m_cnt = 0;
    valid_in = 1'b0;
    addr_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, rand_beat(), 1'b0);
    idle(6);

    // Random traffic ignoring ready (drops, clears, wraps)
    repeat (800) step(1'($urandom_range(0, 99) < 40), rand_beat(), 1'($urandom_range(0, 99) < 3));
    idle(6);

    // Random traffic mostly honouring ready (long back-to-back runs)
    repeat (600) step(1'((m_left <= 1) && ($urandom_range(0, 9) != 0)), rand_beat(),
                      1'($urandom_range(0, 199) == 0));
    idle(8);

    chk("queue_empty", 64'(wq.size()), 64'(0));
    chk("ovf_queue_empty", 64'(ovf_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/par2ser_mem_writer.md
Name: par2ser_mem_writer

Overview:
- Parametrised successor of the two-word parallel-to-serial memory writer.
- Accepts a beat of LANES parallel words of DATA_W bits each.
- Writes the lanes one per cycle, lane 0 first, into a single-port memory write interface (data/addr/wea).
- Sits between the multi-lane datapath and the block-RAM capture buffer. Adds a ready handshake, address wrap at DEPTH, a synchronous address clear, and overflow reporting.

Parameters:
- DATA_W, 18, width of one lane word and of the memory data port.
- LANES, 2, number of lane words per input beat (legal range 2..16).
- ADDR_W, 4, memory address width.
- DEPTH, 16, number of memory locations used (legal range 2..2^ADDR_W); address wraps from DEPTH-1 to 0.

Ports:
- clk, input, 1, system clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- data_in, input, LANES*DATA_W, parallel beat; lane i occupies bits [i*DATA_W +: DATA_W].
- valid_in, input, 1, beat valid.
- ready_out, output, 1, block can accept a beat this cycle (combinational from state).
- addr_clr, input, 1, synchronous request to restart addressing at 0.
- data, output reg, DATA_W, memory write data.
- addr, output reg, ADDR_W, memory write address.
- wea, output reg, 1, memory write enable, one cycle per lane word.
- busy, output, 1, serialisation in progress (state SHIFT).
- overflow, output reg, 1, one-cycle pulse when valid_in is high while ready_out is low.

Behaviour:
- Reset values: data=0, addr=0, wea=0, overflow=0; state IDLE; lane counter 0; holding register 0.
- Reset asserted mid-serialisation aborts the beat. No further wea until a new beat is accepted.
- Accept condition: valid_in && ready_out at a rising edge. On accept:
  - all LANES words are captured into the holding register;
  - the lane counter is set to 0;
  - state becomes SHIFT.
- ready_out is 1 in IDLE. In SHIFT it is 1 only while the lane counter equals LANES-1, which allows back-to-back beats with no bubble.
- State IDLE:
  - wea=0.
  - An accept moves to SHIFT.
- State SHIFT, each cycle:
  - registered outputs for the cycle are data = holding[lane counter] and wea=1;
  - the lane counter increments.
  - On the last lane: a new accept in the same cycle reloads the holding register and stays in SHIFT; otherwise the block goes to IDLE.
- Latency: the first wea for a beat is asserted 1 cycle after the accept edge. A beat occupies exactly LANES consecutive wea cycles. Sustained throughput is 1 beat per LANES cycles with no gaps.
- Address: addr holds the address of the current write. After each wea cycle, the next write uses addr+1, or 0 when addr = DEPTH-1 (wrap).
  - The first write after reset goes to address 0.
  - Addresses are not reset between beats.
- addr_clr:
  - In IDLE, addr is set to 0 on the next edge.
  - In SHIFT, the request is latched and applied after the current beat's last write, so the next beat starts at 0 and the current beat is never split.
  - If addr_clr and an accept occur on the same edge in IDLE, the accepted beat starts at 0.
- Overflow: valid_in=1 while ready_out=0 drops the beat. The holding register is untouched, and overflow pulses 1 on the following cycle.
- data retains its last value when wea=0.

Optional Feature:
- OVERFLOW_CNT_EN:
  - Defined: adds output drop_count[15:0], reset to 0. It increments on each dropped beat and saturates at 16'hFFFF. It is cleared by addr_clr with the same timing as the address clear.
  - Undefined: no port and no counter; overflow pulse only.

Test Plan:
- LANES=2, reset, one beat {lane1=18'h2_0002, lane0=18'h1_0001} -> wea high 2 cycles starting 1 cycle after accept: (addr 0, 18'h10001), (addr 1, 18'h20002); then IDLE, ready_out=1.
- LANES=4, valid_in held high for 3 beats -> 12 consecutive wea cycles with no gaps. ready_out is high only on cycles 0, 4, 8 of the stream; addresses 0..11.
- DEPTH=16, LANES=2, 9 beats -> the 9th beat writes addresses 0 and 1 (wrap after 15). No overflow.
- LANES=4, valid_in pulsed at lane counter 1 -> beat dropped, overflow pulse 1 cycle; current beat's 4 words are unaltered. With OVERFLOW_CNT_EN, drop_count=1.
- addr_clr asserted during lane 1 of a LANES=4 beat at addr 6 -> beat completes at addresses 6..9; next beat starts at addr 0.
- reset_n low during lane 2 of a beat -> wea=0 and addr=0 immediately. The next beat writes from address 0 with its own data.
